instruction_cache: RTL and testbench

Direct-mapped, read-only instruction cache sitting between the pipeline fetch stage and `instruction_memory`. It drives that memory's block-read handshake (`READ`/`ADDRESS[27:0]`) as the initiator, consumes `READDATA[127:0]` when `BUSYWAIT` drops, and serves 32-bit instructions to the CPU. Hits are served with zero added latency, and misses stall the fetch stage via `BUSYWAIT`.

---
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_line_array.sv | 46 ++++
 rtl/instruction_cache.sv | 141 ++++++++++++++
 tb/tb_instruction_cache.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Block geometry, the controller state encoding and the word-select helper.
package icache_pkg;

    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned MEM_ADDR_W      = 28;
    localparam int unsigned WORDS_PER_BLOCK = BLOCK_W / WORD_W;
    localparam int unsigned WORD_SEL_W      = 2;
    localparam int unsigned WORD_SEL_LSB    = 2;
    localparam int unsigned BLOCK_OFS_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_READ = 2'd1,
        S_UPDATE   = 2'd2
    } icache_state_e;

    // Word n of a block occupies bits [32n+31:32n].
    function automatic logic [WORD_W-1:0] select_word(
        input logic [BLOCK_W-1:0]    block,
        input logic [WORD_SEL_W-1:0] sel
    );
        return block[sel*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache: one write port driven by
// the fill FSM, one combinational read port; valid bits clear asynchronously.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned IDX_W    = $clog2(NUM_SETS),
    parameter int unsigned TAG_W    = MEM_ADDR_W - IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0] wr_data,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data
);

    logic [NUM_SETS-1:0] valid;
    logic [TAG_W-1:0]    tags  [NUM_SETS];
    logic [BLOCK_W-1:0]  blocks[NUM_SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]   <= wr_tag;
            blocks[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = blocks[rd_idx];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with zero-latency hits and a
// block-read miss handler. Define ICACHE_STATS_EN to add hit/miss counters.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CPU_READ,
    input  logic [31:0]           PC,
    output logic [WORD_W-1:0]     INSTRUCTION,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
    input  logic [BLOCK_W-1:0]    MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]           HIT_COUNT,
    output logic [31:0]           MISS_COUNT
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W = MEM_ADDR_W - IDX_W;

    icache_state_e state, state_next;

    logic [MEM_ADDR_W-1:0] pc_block;
    logic [IDX_W-1:0]      pc_idx;
    logic [TAG_W-1:0]      pc_tag;
    logic [WORD_SEL_W-1:0] pc_word;
    logic                  unused_pc_lsb;

    logic [MEM_ADDR_W-1:0] miss_addr;
    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [BLOCK_W-1:0]    line_data;

    logic lookup_hit;
    logic hit;
    logic miss_start;
    logic fill_en;
    logic busy;

    assign pc_block      = PC[31:BLOCK_OFS_W];
    assign pc_idx        = pc_block[IDX_W-1:0];
    assign pc_tag        = pc_block[MEM_ADDR_W-1:IDX_W];
    assign pc_word       = PC[WORD_SEL_LSB +: WORD_SEL_W];
    assign unused_pc_lsb = ^PC[1:0];

    icache_line_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_lines (
        .clk      (CLK),
        .rst_n    (RESET),
        .wr_en    (fill_en),
        .wr_idx   (miss_addr[IDX_W-1:0]),
        .wr_tag   (miss_addr[MEM_ADDR_W-1:IDX_W]),
        .wr_data  (MEM_READDATA),
        .rd_idx   (pc_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data)
    );

    assign lookup_hit = CPU_READ && line_valid && (line_tag == pc_tag);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        MEM_READ   = 1'b0;
        hit        = 1'b0;
        miss_start = 1'b0;
        fill_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (lookup_hit) begin
                    hit = 1'b1;
                end else if (CPU_READ) begin
                    busy       = 1'b1;
                    miss_start = 1'b1;
                    state_next = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                busy     = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    fill_en    = 1'b1;
                    state_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                busy       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Gated by RESET so the stall drops while reset is held, even with a pending miss request.
    assign BUSYWAIT    = busy && RESET;
    assign INSTRUCTION = hit ? select_word(line_data, pc_word) : '0;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            miss_addr <= '0;
        end else if (miss_start) begin
            miss_addr <= pc_block;
        end
    end

    assign MEM_ADDRESS = miss_addr;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            if (hit)        HIT_COUNT  <= HIT_COUNT + 32'd1;
            if (miss_start) MISS_COUNT <= MISS_COUNT + 32'd1;
        end
    end
`else
    // Statistics counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed self-checking bench for instruction_cache with a hand-driven
// block-read memory responder.
module tb_instruction_cache;

    logic         CLK;
    logic         RESET;
    logic         CPU_READ;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
    logic [31:0]  HIT_COUNT;
    logic [31:0]  MISS_COUNT;
`endif

    int compared;
    int mismatched;

    localparam logic [127:0] BLK0 = {32'h44443333, 32'h33332222, 32'h22221111, 32'h11110000};
    localparam logic [127:0] BLK8 = {32'hDDDD0003, 32'hDDDD0002, 32'hDDDD0001, 32'hDDDD0000};
    localparam logic [127:0] BLK1 = {32'hA1A1A1A3, 32'hA1A1A1A2, 32'hA1A1A1A1, 32'hA1A1A1A0};
    localparam logic [127:0] BLK2 = {32'hC2C2C2C3, 32'hC2C2C2C2, 32'hC2C2C2C1, 32'hC2C2C2C0};

    instruction_cache #(.NUM_SETS(8)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CPU_READ     (CPU_READ),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a missing PC: stall is immediate, request appears after one edge.
    task automatic start_miss(input string tag, input logic [31:0] pc, input logic [27:0] exp_addr);
        PC       = pc;
        CPU_READ = 1'b1;
        #1;
        check({tag, " busy_now"}, BUSYWAIT, 1'b1);
        check({tag, " no_req_yet"}, MEM_READ, 1'b0);
        @(posedge CLK); #1;
        check({tag, " mem_read"}, MEM_READ, 1'b1);
        check({tag, " mem_addr"}, MEM_ADDRESS, exp_addr);
    endtask

    // Hold memory busy for busy_cycles edges, deliver data, then walk UPDATE into IDLE.
    task automatic serve_fill(input string tag, input int busy_cycles, input logic [127:0] data,
                              input logic [31:0] exp_instr);
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = ~data;
        repeat (busy_cycles) begin
            @(posedge CLK); #1;
        end
        check({tag, " still_req"}, MEM_READ, 1'b1);
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = data;
        @(posedge CLK); #1;
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = '0;
        check({tag, " upd_req_drop"}, MEM_READ, 1'b0);
        check({tag, " upd_busy"}, BUSYWAIT, 1'b1);
        @(posedge CLK); #1;
        check({tag, " idle_busy"}, BUSYWAIT, 1'b0);
        check({tag, " instr"}, INSTRUCTION, exp_instr);
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        RESET        = 1'b0;
        CPU_READ     = 1'b0;
        PC           = 32'h0;
        MEM_READDATA = '0;
        MEM_BUSYWAIT = 1'b1;

        #2;
        check("rst instr", INSTRUCTION, 32'h0);
        check("rst busy", BUSYWAIT, 1'b0);
        check("rst mem_read", MEM_READ, 1'b0);
        check("rst mem_addr", MEM_ADDRESS, 28'h0);
        CPU_READ = 1'b1;
        PC       = 32'h4;
        #1;
        check("rst busy_w_req", BUSYWAIT, 1'b0);
        @(posedge CLK); @(posedge CLK); #1;
        check("rst held mem_read", MEM_READ, 1'b0);

        RESET = 1'b1;
        start_miss("miss4", 32'h0000_0004, 28'h0000000);
        serve_fill("miss4", 5, BLK0, 32'h22221111);

        PC = 32'h0000_0008; #1;
        check("hit8 busy", BUSYWAIT, 1'b0);
        check("hit8 instr", INSTRUCTION, 32'h33332222);
        @(posedge CLK); #1;
        check("hit8 no_req", MEM_READ, 1'b0);
        check("hold mem_addr", MEM_ADDRESS, 28'h0000000);

        PC = 32'h0000_0005; #1;
        check("misalign5 instr", INSTRUCTION, 32'h22221111);
        check("misalign5 busy", BUSYWAIT, 1'b0);
        PC = 32'h0000_000F; #1;
        check("hitF instr", INSTRUCTION, 32'h44443333);

        CPU_READ = 1'b0; PC = 32'h0000_0100; #1;
        check("idle busy", BUSYWAIT, 1'b0);
        check("idle instr", INSTRUCTION, 32'h0);
        repeat (3) @(posedge CLK);
        #1;
        check("idle no_req", MEM_READ, 1'b0);

        start_miss("conf80", 32'h0000_0080, 28'h0000008);
        serve_fill("conf80", 2, BLK8, 32'hDDDD0000);
        start_miss("remiss0", 32'h0000_0000, 28'h0000000);
        serve_fill("remiss0", 0, BLK0, 32'h11110000);
        PC = 32'h0000_0084; #1;
        check("evicted80 busy", BUSYWAIT, 1'b1);
        CPU_READ = 1'b0; #1;

        // Fetch request withdrawn mid-fill; the line must still be installed.
        start_miss("drop14", 32'h0000_0014, 28'h0000001);
        CPU_READ = 1'b0;
        serve_fill("drop14", 3, BLK1, 32'h0);
        CPU_READ = 1'b1; PC = 32'h0000_0018; #1;
        check("drop14 hit busy", BUSYWAIT, 1'b0);
        check("drop14 hit instr", INSTRUCTION, 32'hA1A1A1A2);

        start_miss("abort24", 32'h0000_0024, 28'h0000002);
        @(posedge CLK); #1;
        #2 RESET = 1'b0;
        #1;
        check("abort mem_read", MEM_READ, 1'b0);
        check("abort busy", BUSYWAIT, 1'b0);
        check("abort mem_addr", MEM_ADDRESS, 28'h0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        start_miss("after_abort24", 32'h0000_0024, 28'h0000002);
        serve_fill("after_abort24", 1, BLK2, 32'hC2C2C2C1);
        PC = 32'h0000_0004; #1;
        check("cleared4 busy", BUSYWAIT, 1'b1);
        PC = 32'h0000_0014; #1;
        check("cleared14 busy", BUSYWAIT, 1'b1);
        CPU_READ = 1'b0; #1;
        @(posedge CLK); #1;
        check("cleared no_req", MEM_READ, 1'b0);

`ifdef ICACHE_STATS_EN
        RESET = 1'b0; #1;
        check("stats rst hit", HIT_COUNT, 32'd0);
        check("stats rst miss", MISS_COUNT, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        start_miss("stats30", 32'h0000_0030, 28'h0000003);
        serve_fill("stats30", 1, BLK1, 32'hA1A1A1A0);
        CPU_READ = 1'b0; #1;
        repeat (2) begin
            CPU_READ = 1'b1; PC = 32'h0000_0034;
            @(posedge CLK); #1;
            CPU_READ = 1'b0;
        end
        start_miss("stats50", 32'h0000_0050, 28'h0000005);
        serve_fill("stats50", 1, BLK2, 32'hC2C2C2C0);
        CPU_READ = 1'b0; #1;
        check("stats hit", HIT_COUNT, 32'd2);
        check("stats miss", MISS_COUNT, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
